// File: rtl/n_bit_accumulator.sv
// n_bit_accumulator: accumulates a run of len unsigned samples over a
// valid/ready input stream and presents the modulo-2^N sum plus a sticky
// carry-out flag on a valid/ready output.

module n_bit_ripple_carry_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         cout,
    output logic [N-1:0] sum
);

    logic carry;

    // Bit-serial carry chain; the carry is a procedural variable so the
    // chain stays a single combinational process.
    always_comb begin
        sum   = '0;
        carry = cin;
        for (int unsigned i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

module n_bit_accumulator #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [N-1:0]     acc;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     add_sum;
    logic             add_cout;
    logic             xfer;

    n_bit_ripple_carry_adder #(
        .N (N)
    ) u_adder (
        .a    (acc),
        .b    (in_data),
        .cin  (1'b0),
        .cout (add_cout),
        .sum  (add_sum)
    );

    // Handshake outputs come from the state register only.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_sum   = acc;
    assign out_ovf   = ovf;
    assign xfer      = in_valid & in_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                if (xfer && (cnt == CNT_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: clear on start, accumulate only on transferring cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        ovf <= 1'b0;
                        cnt <= len;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc <= add_sum;
                        ovf <= ovf | add_cout;
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_n_bit_accumulator.sv
// Directed bench for n_bit_accumulator (N=8, CNT_W=4).

module tb_n_bit_accumulator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_ovf;
    logic       busy;

    int tests;
    int fails;

    n_bit_accumulator #(
        .N     (8),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 4'd0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Basic run: 10+20+30
        start = 1'b1; len = 4'd3;
        tick();
        check("basic_busy", busy, 1);
        check("basic_in_ready", in_ready, 1);
        start = 1'b0; in_valid = 1'b1; in_data = 8'd10;
        tick();
        in_data = 8'd20;
        tick();
        in_data = 8'd30;
        check("basic_no_early_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        check("basic_out_valid", out_valid, 1);
        check("basic_sum", out_sum, 60);
        check("basic_ovf", out_ovf, 0);
        check("basic_done_in_ready", in_ready, 0);
        tick();
        check("basic_valid_one_cycle", out_valid, 0);
        check("basic_idle_busy", busy, 0);

        // Overflow: 200+100 = 300 -> 44, carry
        start = 1'b1; len = 4'd2;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 8'd200;
        tick();
        in_data = 8'd100;
        tick();
        in_valid = 1'b0;
        check("ovf_out_valid", out_valid, 1);
        check("ovf_sum", out_sum, 44);
        check("ovf_flag", out_ovf, 1);
        tick();

        // Back-pressure: 5, gap, 6, gap, 7 then out_ready low 5 cycles
        out_ready = 1'b0;
        start = 1'b1; len = 4'd3;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 8'd5;
        tick();
        in_valid = 1'b0; in_data = 8'd99;
        tick();
        check("bp_gap_in_ready", in_ready, 1);
        in_valid = 1'b1; in_data = 8'd6;
        tick();
        in_valid = 1'b0; in_data = 8'd99;
        tick();
        check("bp_gap_not_done", out_valid, 0);
        in_valid = 1'b1; in_data = 8'd7;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_sum", out_sum, 18);
            check("bp_hold_ovf", out_ovf, 0);
            check("bp_hold_in_ready", in_ready, 0);
            // start in DONE must be ignored
            start = (i == 2); len = 4'd3;
            tick();
        end
        start = 1'b0;
        check("bp_still_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        check("bp_released", out_valid, 0);

        // Zero length: straight to DONE, no sample taken
        start = 1'b1; len = 4'd0; in_valid = 1'b1; in_data = 8'd55;
        tick();
        start = 1'b0;
        check("zero_out_valid", out_valid, 1);
        check("zero_sum", out_sum, 0);
        check("zero_ovf", out_ovf, 0);
        check("zero_in_ready", in_ready, 0);
        tick();
        in_valid = 1'b0;
        check("zero_back_idle", busy, 0);

        // Max length, 15 x 255, with start pulsed mid-run
        start = 1'b1; len = 4'd15;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 8'd255;
        for (int i = 0; i < 15; i++) begin
            start = (i == 5); len = 4'd2;
            if (i == 14) check("max_not_done_early", out_valid, 0);
            tick();
        end
        start = 1'b0; in_valid = 1'b0;
        check("max_out_valid", out_valid, 1);
        check("max_sum", out_sum, 241);
        check("max_ovf", out_ovf, 1);
        tick();

        // Reset mid-run after 2 of 4 samples
        start = 1'b1; len = 4'd4;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 8'd1;
        tick();
        in_data = 8'd2;
        tick();
        in_valid = 1'b0;
        check("midrst_pre_sum", out_sum, 3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", out_sum, 0);
        #3 rst_n = 1'b1;
        start = 1'b1; len = 4'd1;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 8'd7;
        check("post_rst_accum", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("post_rst_valid", out_valid, 1);
        check("post_rst_sum", out_sum, 7);
        check("post_rst_ovf", out_ovf, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
